// File: rtl/barcode_scan_ctrl.sv
// -----------------------------------------------------------------------------
// barcode_scan_ctrl
//
// Sequences an EAN-13 threshold scanner. The block picks the row the scanner
// samples in each frame. It captures the 13 digits the scanner reports and
// verifies the EAN-13 check digit. A failed read hops to the next candidate
// row. A code is accepted only after CONFIRM_N identical good reads in a row.
// Each newly confirmed code is streamed to a UART transmitter as ASCII digits
// followed by CR LF.
//
// Ports
//   clk          pixel clock
//   rst_n        synchronous reset, active low
//   frame_start  one-cycle pulse at the start of each frame
//   loc_x/loc_y  current pixel column / row
//   scan_data    13 x 4-bit digits; digit i = scan_data[4i+3:4i], digit 0 first
//   scan_row     row the scanner samples; results appear at row scan_row+2
//   code_digits  last published code, same packing as scan_data
//   code_valid   one-cycle pulse when code_digits updates
//   tx_data      byte to the UART
//   tx_valid     tx_data valid; holds until tx_ready accepts the byte
//   tx_ready     UART accepts the byte
//   busy         high whenever the controller is not waiting for a capture
// -----------------------------------------------------------------------------
module barcode_scan_ctrl #(
  parameter int ROW_BASE     = 120,
  parameter int ROW_STEP     = 4,
  parameter int ROW_COUNT    = 8,
  parameter int CONFIRM_N    = 2,
  parameter int CLEAR_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [9:0]  loc_x,
  input  logic [9:0]  loc_y,
  input  logic [51:0] scan_data,
  output logic [9:0]  scan_row,
  output logic [51:0] code_digits,
  output logic        code_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  localparam int         ROW_IDX_W = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
  localparam logic [3:0] CONFIRM_W = 4'(CONFIRM_N);
  localparam logic [7:0] CLEAR_W   = 8'(CLEAR_FRAMES);
  localparam logic [9:0] CAP_COL   = 10'd13;
  localparam logic [3:0] LAST_BYTE = 4'd14;

  typedef enum logic [1:0] {
    WAIT_CAP,
    CHECK,
    JUDGE,
    SEND
  } state_t;

  state_t                 state_q, state_d;
  logic [51:0]            cand_q;
  logic [51:0]            prev_q;
  logic [51:0]            last_sent_q;
  logic                   last_valid_q;
  logic [4:0]             acc_q;
  logic [3:0]             step_q;
  logic [3:0]             match_cnt_q;
  logic [7:0]             fail_cnt_q;
  logic [ROW_IDX_W-1:0]   row_idx_q, row_idx_d;
  logic [3:0]             byte_idx_q;
  logic                   frame_open_q;  // a frame has started since reset
  logic                   cap_seen_q;    // current frame already produced a read

  // Control strobes from the FSM to the datapath.
  logic                   capture_hit;
  logic                   do_capture;
  logic                   do_fail;
  logic                   do_pass;
  logic                   start_send;
  logic                   tx_fire;

  // Checksum / judgement helpers.
  logic [3:0]             digit_k;
  logic [5:0]             term;
  logic [5:0]             acc_sum;
  logic [4:0]             acc_next;
  logic [4:0]             check_calc;
  logic                   digits_ok;
  logic                   cand_ok;
  logic [3:0]             match_next;
  logic [7:0]             fail_next;
  logic                   publish_ok;

  function automatic logic [9:0] row_of(input logic [ROW_IDX_W-1:0] idx);
    return 10'(ROW_BASE + ROW_STEP * int'(idx));
  endfunction

  // Byte idx of the outgoing record: 13 ASCII digits, then CR, then LF.
  function automatic logic [7:0] tx_byte(input logic [51:0] code,
                                         input logic [3:0]  idx);
    logic [7:0] b;
    if (idx < 4'd13) b = 8'h30 + {4'h0, code[{idx, 2'b00} +: 4]};
    else if (idx == 4'd13) b = 8'h0D;
    else b = 8'h0A;
    return b;
  endfunction

  assign capture_hit = (loc_y == scan_row + 10'd2) && (loc_x == CAP_COL);
  assign tx_fire     = (state_q == SEND) && tx_valid && tx_ready;
  assign busy        = (state_q != WAIT_CAP);

  // Weighted running sum, reduced mod 10 each step so it fits in 5 bits.
  assign digit_k  = cand_q[{step_q, 2'b00} +: 4];
  assign term     = step_q[0] ? ({2'b00, digit_k} * 6'd3) : {2'b00, digit_k};
  assign acc_sum  = {1'b0, acc_q} + term;
  assign acc_next = 5'(acc_sum % 6'd10);

  // (10 - acc) % 10 without a second modulo.
  assign check_calc = (acc_q == 5'd0) ? 5'd0 : (5'd10 - acc_q);

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (cand_q[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
  end

  assign cand_ok = digits_ok && (check_calc == {1'b0, cand_q[51:48]});

  assign match_next = (cand_q != prev_q)        ? 4'd1 :
                      (match_cnt_q == 4'd15)    ? 4'd15 :
                                                  match_cnt_q + 4'd1;
  assign fail_next  = (fail_cnt_q == CLEAR_W) ? CLEAR_W : fail_cnt_q + 8'd1;
  assign publish_ok = (match_next >= CONFIRM_W) &&
                      (!last_valid_q || (cand_q != last_sent_q));

  // Row index advances on every failed read and wraps after the last row.
  assign row_idx_d = !do_fail ? row_idx_q :
                     (row_idx_q == ROW_IDX_W'(ROW_COUNT - 1)) ? '0 :
                     row_idx_q + ROW_IDX_W'(1);

  // NOTE: every signal this block writes gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    do_capture = 1'b0;
    do_fail    = 1'b0;
    do_pass    = 1'b0;
    start_send = 1'b0;
    case (state_q)
      WAIT_CAP: begin
        // A capture on the same cycle as frame_start wins: no fail counted.
        if (capture_hit) begin
          do_capture = 1'b1;
          state_d    = CHECK;
        end else if (frame_start && frame_open_q && !cap_seen_q) begin
          do_fail = 1'b1;
        end
      end
      CHECK: begin
        if (step_q == 4'd11) state_d = JUDGE;
      end
      JUDGE: begin
        if (cand_ok) begin
          do_pass = 1'b1;
          if (publish_ok) begin
            start_send = 1'b1;
            state_d    = SEND;
          end else begin
            state_d = WAIT_CAP;
          end
        end else begin
          do_fail = 1'b1;
          state_d = WAIT_CAP;
        end
      end
      SEND: begin
        if (tx_fire && (byte_idx_q == LAST_BYTE)) state_d = WAIT_CAP;
      end
      default: state_d = WAIT_CAP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= WAIT_CAP;
      cand_q       <= '0;
      prev_q       <= '0;
      last_sent_q  <= '0;
      last_valid_q <= 1'b0;
      acc_q        <= '0;
      step_q       <= '0;
      match_cnt_q  <= '0;
      fail_cnt_q   <= '0;
      row_idx_q    <= '0;
      byte_idx_q   <= '0;
      frame_open_q <= 1'b0;
      cap_seen_q   <= 1'b0;
      scan_row     <= row_of('0);
      code_digits  <= '0;
      code_valid   <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_idx_q  <= row_idx_d;
      code_valid <= 1'b0;

      // Frame bookkeeping. A frame that begins while the controller is busy
      // is excused: its capture point may pass unseen.
      if (frame_start) begin
        frame_open_q <= 1'b1;
        scan_row     <= row_of(row_idx_d);
      end
      if (do_capture) cap_seen_q <= 1'b1;
      else if (frame_start) cap_seen_q <= (state_q != WAIT_CAP);

      if (do_capture) begin
        cand_q <= scan_data;
        acc_q  <= '0;
        step_q <= '0;
      end

      if (state_q == CHECK) begin
        acc_q  <= acc_next;
        step_q <= step_q + 4'd1;
      end

      if (do_fail) begin
        match_cnt_q <= '0;
        fail_cnt_q  <= fail_next;
        if (fail_next == CLEAR_W) last_valid_q <= 1'b0;
      end

      if (do_pass) begin
        fail_cnt_q  <= '0;
        match_cnt_q <= match_next;
        prev_q      <= cand_q;
      end

      if (start_send) begin
        code_digits  <= cand_q;
        code_valid   <= 1'b1;
        last_sent_q  <= cand_q;
        last_valid_q <= 1'b1;
        byte_idx_q   <= '0;
        tx_data      <= tx_byte(cand_q, 4'd0);
        tx_valid     <= 1'b1;
      end

      // tx_data only moves on an accepted byte, so it is stable while stalled.
      if (tx_fire) begin
        if (byte_idx_q == LAST_BYTE) begin
          tx_valid <= 1'b0;
        end else begin
          byte_idx_q <= byte_idx_q + 4'd1;
          tx_data    <= tx_byte(cand_q, byte_idx_q + 4'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_barcode_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_barcode_scan_ctrl
//
// Directed frames drive the controller. A frame-level reference model predicts
// the scan row, each publish (code, cycle) and the outgoing byte stream. The
// model is based on the EAN-13 rules, row hopping, confirmation and forgetting.
// A negedge monitor compares the DUT against the model every cycle. Literal
// checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_barcode_scan_ctrl;

  localparam int ROW_BASE     = 120;
  localparam int ROW_STEP     = 4;
  localparam int ROW_COUNT    = 8;
  localparam int CONFIRM_N    = 2;
  localparam int CLEAR_FRAMES = 30;
  localparam int FRAME_LEN    = 48;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [9:0]  loc_x, loc_y;
  logic [51:0] scan_data;
  logic [9:0]  scan_row;
  logic [51:0] code_digits;
  logic        code_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;

  always #5 clk = ~clk;

  barcode_scan_ctrl #(
    .ROW_BASE(ROW_BASE), .ROW_STEP(ROW_STEP), .ROW_COUNT(ROW_COUNT),
    .CONFIRM_N(CONFIRM_N), .CLEAR_FRAMES(CLEAR_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .loc_x(loc_x), .loc_y(loc_y), .scan_data(scan_data),
    .scan_row(scan_row), .code_digits(code_digits), .code_valid(code_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_row_idx, m_match, m_fail;
  logic [51:0] m_prev, m_last;
  bit          m_last_valid, m_frame_open, m_captured;
  logic [9:0]  exp_row;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_bytes[$];
  bit          cv_pend;
  int          cv_cyc, cv_seen_cyc, obs_cv, last_cap_cyc;
  logic [51:0] cv_code;

  function automatic logic [51:0] mk(input string s);
    logic [51:0] c = '0;
    for (int i = 0; i < 13; i++) c[4*i +: 4] = 4'(s.getc(i) - 8'h30);
    return c;
  endfunction

  function automatic bit ean_ok(input logic [51:0] c);
    int sum = 0;
    for (int i = 0; i < 13; i++) if (c[4*i +: 4] > 4'd9) return 1'b0;
    for (int i = 0; i < 12; i++) sum += (i % 2 == 1) ? 3 * int'(c[4*i +: 4]) : int'(c[4*i +: 4]);
    return ((10 - sum % 10) % 10) == int'(c[51:48]);
  endfunction

  task automatic model_reset();
    m_row_idx = 0; m_match = 0; m_fail = 0;
    m_prev = '0; m_last = '0; m_last_valid = 0;
    m_frame_open = 0; m_captured = 0;
    exp_q.delete(); cv_pend = 0;
    exp_row = 10'(ROW_BASE);
  endtask

  task automatic model_fail();
    m_match   = 0;
    m_row_idx = (m_row_idx + 1) % ROW_COUNT;
    if (m_fail < CLEAR_FRAMES) m_fail++;
    if (m_fail == CLEAR_FRAMES) m_last_valid = 0;
  endtask

  task automatic model_judge(input logic [51:0] c, input int cap);
    if (!ean_ok(c)) begin
      model_fail();
    end else begin
      m_fail  = 0;
      m_match = (c == m_prev) ? ((m_match < 15) ? m_match + 1 : 15) : 1;
      m_prev  = c;
      if (m_match >= CONFIRM_N && (!m_last_valid || c != m_last)) begin
        m_last = c; m_last_valid = 1;
        for (int i = 0; i < 13; i++) exp_q.push_back(8'h30 + {4'h0, c[4*i +: 4]});
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        cv_pend = 1; cv_cyc = cap + 14; cv_code = c;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic frame_begin();
    @(posedge clk); #1;
    check("busy_at_frame", busy, 0);
    if (m_frame_open && !m_captured) model_fail();
    m_frame_open = 1; m_captured = 0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    exp_row = 10'(ROW_BASE + m_row_idx * ROW_STEP);
  endtask

  task automatic capture(input logic [51:0] c);
    @(posedge clk); #1;
    loc_y = exp_row + 10'd2; loc_x = 10'd13; scan_data = c;
    last_cap_cyc = cyc; m_captured = 1;
    model_judge(c, cyc);
    @(posedge clk); #1;
    loc_x = 10'd0; loc_y = 10'd0;
  endtask

  task automatic run_frame(input logic [51:0] c, input bit do_cap);
    frame_begin();
    idle(2);
    if (do_cap) capture(c); else idle(2);
    idle(FRAME_LEN - 6);
  endtask

  // ---------------- tx_ready driver ----------------
  bit force_low = 0;
  int stall_idx = 0, stall_left = 0;

  always @(posedge clk) begin
    #2;
    if (force_low) tx_ready = 1'b0;
    else if (stall_left > 0 && tx_valid && (15 - exp_q.size()) == stall_idx) begin
      tx_ready = 1'b0;
      stall_left--;
    end else tx_ready = 1'b1;
  end

  // ---------------- compare process ----------------
  bit         mon_en = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_tx_data = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("scan_row", scan_row, exp_row);
      if (code_valid) begin
        check("code_valid_when", (cv_pend && cyc == cv_cyc), 1);
        check("code_digits", code_digits, cv_code);
        check("tx_valid_with_cv", tx_valid, 1);
        obs_cv++; cv_seen_cyc = cyc; cv_pend = 0;
      end else if (cv_pend && cyc >= cv_cyc) begin
        check("code_valid_missing", code_valid, 1);
        cv_pend = 0;
      end
      if (exp_q.size() == 0) check("tx_unexpected", tx_valid, 0);
      if (prev_stall) begin
        check("tx_valid_hold", tx_valid, 1);
        check("tx_data_hold", tx_data, prev_tx_data);
      end
      if (tx_valid && tx_ready && exp_q.size() != 0) begin
        check("tx_byte", tx_data, exp_q.pop_front());
        obs_bytes.push_back(tx_data);
      end
      prev_stall   = tx_valid && !tx_ready;
      prev_tx_data = tx_data;
    end else begin
      prev_stall = 0;
    end
  end

  // ---------------- main sequence ----------------
  logic [51:0] code_a, code_a_bad, code_a_hex, code_b, code_c;
  logic [7:0]  exp1 [15] = '{8'h39, 8'h37, 8'h38, 8'h37, 8'h31, 8'h31, 8'h35,
                            8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h39, 8'h0D, 8'h0A};
  int base_cv, base_bytes;

  initial begin
    code_a     = mk("9787115123459");
    code_a_bad = mk("9787115123458");
    code_b     = mk("0123456789012");
    code_c     = mk("5901234123457");
    // Digit 4 = 0xB keeps the weighted sum congruent but is not a decimal digit.
    code_a_hex = code_a;
    code_a_hex[19:16] = 4'hB;

    rst_n = 1'b0; frame_start = 1'b0; loc_x = '0; loc_y = '0; scan_data = '0;
    model_reset();
    idle(3);
    @(negedge clk);
    check("rst_scan_row", scan_row, 10'd120);
    check("rst_code_digits", code_digits, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("model_pin_a", ean_ok(code_a), 1);
    check("model_pin_bad", ean_ok(code_a_bad), 0);
    check("model_pin_hex", ean_ok(code_a_hex), 0);
    mon_en = 1;
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: two frames of A -> publish after the second, 14-cycle latency.
    run_frame(code_a, 1);
    check("t1_no_cv_frame1", obs_cv, 0);
    run_frame(code_a, 1);
    check("t1_cv_count", obs_cv, 1);
    check("t1_latency", cv_seen_cyc - last_cap_cyc, 14);
    check("t1_code", code_digits, code_a);
    check("t1_byte_count", obs_bytes.size(), 15);
    for (int i = 0; i < 15; i++) check("t1_byte", obs_bytes[i], exp1[i]);

    // 2: bad check digit hops through all rows and wraps back to 120.
    base_cv = obs_cv;
    for (int i = 0; i < 9; i++) begin
      frame_begin();
      check("t2_row", scan_row, 10'(120 + 4 * (i % 8)));
      idle(2);
      capture(code_a_bad);
      idle(FRAME_LEN - 6);
    end
    check("t2_no_publish", obs_cv - base_cv, 0);

    // 5: C then B, B -> a single publish, of B.
    base_cv = obs_cv;
    run_frame(code_c, 1);
    run_frame(code_b, 1);
    check("t5_no_cv_yet", obs_cv - base_cv, 0);
    run_frame(code_b, 1);
    check("t5_one_publish", obs_cv - base_cv, 1);
    check("t5_code_b", code_digits, code_b);

    // 3: A twice, tx_ready low for 50 cycles on byte 3.
    base_cv = obs_cv; base_bytes = obs_bytes.size();
    run_frame(code_a, 1);
    stall_idx = 2; stall_left = 50;
    frame_begin();
    idle(2);
    capture(code_a);
    idle(35);
    @(negedge clk);
    check("t3_stall_data", tx_data, 8'h38);
    check("t3_stall_valid", tx_valid, 1);
    idle(70);
    check("t3_one_publish", obs_cv - base_cv, 1);
    check("t3_all_bytes", obs_bytes.size() - base_bytes, 15);

    // 4: same code 10 frames -> one publish; 30 fails forget it; republish.
    base_cv = obs_cv;
    for (int i = 0; i < 10; i++) run_frame(code_c, 1);
    check("t4_single_publish", obs_cv - base_cv, 1);
    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0: run_frame(code_a_bad, 1);
        1: run_frame(code_a, 0);
        default: run_frame(code_a_hex, 1);
      endcase
    end
    check("t4_no_publish_on_fail", obs_cv - base_cv, 1);
    run_frame(code_c, 1);
    run_frame(code_c, 1);
    check("t4_republish", obs_cv - base_cv, 2);
    check("t4_code_c", code_digits, code_c);

    // 6: reset during byte 7 of a transfer drops it for good.
    run_frame(code_a, 1);
    frame_begin();
    idle(2);
    capture(code_a);
    base_bytes = obs_bytes.size();
    begin : wait_byte7
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1;
        if (obs_bytes.size() - base_bytes == 6) disable wait_byte7;
      end
    end
    check("t6_reached_byte7", obs_bytes.size() - base_bytes, 6);
    mon_en = 0; force_low = 1; rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    @(negedge clk);
    check("t6_tx_valid", tx_valid, 0);
    check("t6_scan_row", scan_row, 10'd120);
    check("t6_busy", busy, 0);
    check("t6_code_valid", code_valid, 0);
    mon_en = 1;
    @(posedge clk); #1; rst_n = 1'b1; force_low = 0;
    idle(40);
    check("t6_not_resumed", obs_bytes.size() - base_bytes, 6);
    base_cv = obs_cv;
    run_frame(code_c, 1);
    run_frame(code_c, 1);
    check("t6_post_reset_publish", obs_cv - base_cv, 1);

    idle(10);
    check("queue_drained", exp_q.size(), 0);
    check("no_pending_cv", cv_pend, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
